// File: rtl/clock_switch_gen_if.sv
// Select input and switched-clock outputs of clock_switch_gen.
// The master side drives the select; the slave side (the switch) drives the status.
interface clock_switch_gen_if;
    logic sel_clkb;
    logic clk_o;
    logic active_b;
    logic switching;

    modport master (
        output sel_clkb,
        input  clk_o,
        input  active_b,
        input  switching
    );

    modport slave (
        input  sel_clkb,
        output clk_o,
        output active_b,
        output switching
    );
endinterface

// File: rtl/clock_switch_gen.sv
// Glitch-free switch between two divided clocks A and B generated from clk.
// clk_o is parked low during a handover and only resumes on a source's rising phase edge.
module clock_switch_gen #(
    parameter int unsigned HALF_A = 2,
    parameter int unsigned HALF_B = 7,
    parameter int unsigned CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    clock_switch_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(HALF_A - 1);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(HALF_B - 1);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_A2B = 2'd1,
        S_B   = 2'd2,
        S_B2A = 2'd3
    } state_t;

    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic             phase_a_q, phase_a_d;
    logic             phase_b_q, phase_b_d;
    logic             sync1_q;
    logic             sel_s_q;
    state_t           state_q, state_d;
    logic             clk_o_q, clk_o_d;
    logic             active_b_q, active_b_d;
    logic             switching_q, switching_d;
    logic             rise_a_s, rise_b_s;

    // Free-running dividers: phase_x_d is the phase value after the coming edge.
    always_comb begin
        cnt_a_d   = cnt_a_q;
        phase_a_d = phase_a_q;
        cnt_b_d   = cnt_b_q;
        phase_b_d = phase_b_q;
        if (cnt_a_q == A_LAST) begin
            cnt_a_d   = '0;
            phase_a_d = ~phase_a_q;
        end else begin
            cnt_a_d   = cnt_a_q + CNT_W'(1);
            phase_a_d = phase_a_q;
        end
        if (cnt_b_q == B_LAST) begin
            cnt_b_d   = '0;
            phase_b_d = ~phase_b_q;
        end else begin
            cnt_b_d   = cnt_b_q + CNT_W'(1);
            phase_b_d = phase_b_q;
        end
    end

    assign rise_a_s = ~phase_a_q & phase_a_d;
    assign rise_b_s = ~phase_b_q & phase_b_d;

    // Handover FSM; entering a source drives clk_o high on the same edge so its first high phase is full.
    always_comb begin
        state_d = state_q;
        clk_o_d = 1'b0;
        case (state_q)
            S_A: begin
                clk_o_d = phase_a_d;
                if (sel_s_q && !phase_a_d) begin
                    state_d = S_A2B;
                end else begin
                    state_d = S_A;
                end
            end
            S_A2B: begin
                if (!sel_s_q) begin
                    if (rise_a_s) begin
                        state_d = S_A;
                        clk_o_d = 1'b1;
                    end else begin
                        state_d = S_A2B;
                    end
                end else if (rise_b_s) begin
                    state_d = S_B;
                    clk_o_d = 1'b1;
                end else begin
                    state_d = S_A2B;
                end
            end
            S_B: begin
                clk_o_d = phase_b_d;
                if (!sel_s_q && !phase_b_d) begin
                    state_d = S_B2A;
                end else begin
                    state_d = S_B;
                end
            end
            S_B2A: begin
                if (sel_s_q) begin
                    if (rise_b_s) begin
                        state_d = S_B;
                        clk_o_d = 1'b1;
                    end else begin
                        state_d = S_B2A;
                    end
                end else if (rise_a_s) begin
                    state_d = S_A;
                    clk_o_d = 1'b1;
                end else begin
                    state_d = S_B2A;
                end
            end
            default: begin
                state_d = S_A;
                clk_o_d = 1'b0;
            end
        endcase
        active_b_d  = (state_d == S_B)   || (state_d == S_A2B);
        switching_d = (state_d == S_A2B) || (state_d == S_B2A);
    end

    // All state, including the two-flop select synchronizer and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            phase_a_q   <= 1'b0;
            phase_b_q   <= 1'b0;
            sync1_q     <= 1'b0;
            sel_s_q     <= 1'b0;
            state_q     <= S_A;
            clk_o_q     <= 1'b0;
            active_b_q  <= 1'b0;
            switching_q <= 1'b0;
        end else begin
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            phase_a_q   <= phase_a_d;
            phase_b_q   <= phase_b_d;
            sync1_q     <= bus.sel_clkb;
            sel_s_q     <= sync1_q;
            state_q     <= state_d;
            clk_o_q     <= clk_o_d;
            active_b_q  <= active_b_d;
            switching_q <= switching_d;
        end
    end

    assign bus.clk_o     = clk_o_q;
    assign bus.active_b  = active_b_q;
    assign bus.switching = switching_q;

endmodule

// File: tb/tb_clock_switch_gen.sv
// Directed bench for clock_switch_gen with HALF_A=2, HALF_B=7.
// n counts rising edges since the last reset release; expected waveforms are written against n.
module tb_clock_switch_gen;

    logic clk;
    logic rst;
    int   n;
    int   checks;
    int   fails;

    // pulse-width monitor state
    int   run_len;
    logic prev_clk;
    logic run_valid;
    int   min_hi;
    int   min_lo;

    logic exp_clk;
    logic exp_ab;
    logic exp_sw;

    clock_switch_gen_if bus ();

    clock_switch_gen #(
        .HALF_A (2),
        .HALF_B (7),
        .CNT_W  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Measure complete high/low runs of clk_o; runs cut by reset are discarded.
    always @(posedge clk) begin
        logic r;
        r = rst;
        #1;
        if (r) begin
            run_valid = 1'b0;
            run_len   = 0;
            prev_clk  = bus.clk_o;
        end else if (bus.clk_o === prev_clk) begin
            run_len = run_len + 1;
        end else begin
            if (run_valid) begin
                if (prev_clk === 1'b1) begin
                    if (run_len < min_hi) min_hi = run_len;
                end else begin
                    if (run_len < min_lo) min_lo = run_len;
                end
            end
            run_valid = 1'b1;
            run_len   = 1;
            prev_clk  = bus.clk_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        n = n + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sel_clkb = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.clk_o !== 1'b0) begin fails++; $display("FAIL reset_clk_o: got %b expected 0", bus.clk_o); end
            checks++;
            if (bus.active_b !== 1'b0) begin fails++; $display("FAIL reset_active_b: got %b expected 0", bus.active_b); end
            checks++;
            if (bus.switching !== 1'b0) begin fails++; $display("FAIL reset_switching: got %b expected 0", bus.switching); end
        end
        rst = 1'b0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_clk = ((n / 2) % 2) == 1;
            checks++;
            if (bus.clk_o !== exp_clk) begin fails++; $display("FAIL hold_a_clk_o n=%0d: got %b expected %b", n, bus.clk_o, exp_clk); end
            checks++;
            if (bus.active_b !== 1'b0) begin fails++; $display("FAIL hold_a_active_b n=%0d: got %b expected 0", n, bus.active_b); end
        end
    endtask

    task automatic test_a_to_b();
        bus.sel_clkb = 1'b1;
        for (int k = 41; k <= 70; k++) begin
            tick();
            exp_clk = (n <= 43) ? (((n / 2) % 2) == 1) : (n <= 48) ? 1'b0 : (((n / 7) % 2) == 1);
            exp_sw  = (n >= 44) && (n <= 48);
            exp_ab  = (n >= 44);
            checks++;
            if (bus.clk_o !== exp_clk) begin fails++; $display("FAIL a2b_clk_o n=%0d: got %b expected %b", n, bus.clk_o, exp_clk); end
            checks++;
            if (bus.switching !== exp_sw) begin fails++; $display("FAIL a2b_switching n=%0d: got %b expected %b", n, bus.switching, exp_sw); end
            checks++;
            if (bus.active_b !== exp_ab) begin fails++; $display("FAIL a2b_active_b n=%0d: got %b expected %b", n, bus.active_b, exp_ab); end
        end
    endtask

    task automatic test_b_to_a();
        for (int k = 71; k <= 100; k++) begin
            tick();
            if (n == 79) bus.sel_clkb = 1'b0;
            exp_clk = (n <= 83) ? (((n / 7) % 2) == 1) : (n <= 85) ? 1'b0 : (((n / 2) % 2) == 1);
            exp_sw  = (n >= 84) && (n <= 85);
            exp_ab  = (n <= 83);
            checks++;
            if (bus.clk_o !== exp_clk) begin fails++; $display("FAIL b2a_clk_o n=%0d: got %b expected %b", n, bus.clk_o, exp_clk); end
            checks++;
            if (bus.switching !== exp_sw) begin fails++; $display("FAIL b2a_switching n=%0d: got %b expected %b", n, bus.switching, exp_sw); end
            checks++;
            if (bus.active_b !== exp_ab) begin fails++; $display("FAIL b2a_active_b n=%0d: got %b expected %b", n, bus.active_b, exp_ab); end
        end
    endtask

    task automatic test_abort();
        for (int k = 101; k <= 125; k++) begin
            tick();
            if (n == 104) bus.sel_clkb = 1'b1;
            if (n == 109) bus.sel_clkb = 1'b0;
            exp_clk = (n >= 108 && n <= 113) ? 1'b0 : (((n / 2) % 2) == 1);
            exp_sw  = (n >= 108) && (n <= 113);
            exp_ab  = exp_sw;
            checks++;
            if (bus.clk_o !== exp_clk) begin fails++; $display("FAIL abort_clk_o n=%0d: got %b expected %b", n, bus.clk_o, exp_clk); end
            checks++;
            if (bus.switching !== exp_sw) begin fails++; $display("FAIL abort_switching n=%0d: got %b expected %b", n, bus.switching, exp_sw); end
            checks++;
            if (bus.active_b !== exp_ab) begin fails++; $display("FAIL abort_active_b n=%0d: got %b expected %b", n, bus.active_b, exp_ab); end
        end
    endtask

    task automatic test_sync_reset();
        bus.sel_clkb = 1'b1;
        for (int k = 126; k <= 149; k++) begin
            tick();
            exp_clk = (n <= 127) ? (((n / 2) % 2) == 1) : (n <= 132) ? 1'b0 : (((n / 7) % 2) == 1);
            exp_ab  = (n >= 128);
            checks++;
            if (bus.clk_o !== exp_clk) begin fails++; $display("FAIL pre_rst_clk_o n=%0d: got %b expected %b", n, bus.clk_o, exp_clk); end
            checks++;
            if (bus.active_b !== exp_ab) begin fails++; $display("FAIL pre_rst_active_b n=%0d: got %b expected %b", n, bus.active_b, exp_ab); end
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.clk_o !== 1'b0) begin fails++; $display("FAIL srst_clk_o: got %b expected 0", bus.clk_o); end
        checks++;
        if (bus.active_b !== 1'b0) begin fails++; $display("FAIL srst_active_b: got %b expected 0", bus.active_b); end
        checks++;
        if (bus.switching !== 1'b0) begin fails++; $display("FAIL srst_switching: got %b expected 0", bus.switching); end
        rst = 1'b0;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_clk = (n <= 3) ? (((n / 2) % 2) == 1) : (n <= 6) ? 1'b0 : (((n / 7) % 2) == 1);
            exp_sw  = (n >= 4) && (n <= 6);
            exp_ab  = (n >= 4);
            checks++;
            if (bus.clk_o !== exp_clk) begin fails++; $display("FAIL post_rst_clk_o n=%0d: got %b expected %b", n, bus.clk_o, exp_clk); end
            checks++;
            if (bus.switching !== exp_sw) begin fails++; $display("FAIL post_rst_switching n=%0d: got %b expected %b", n, bus.switching, exp_sw); end
            checks++;
            if (bus.active_b !== exp_ab) begin fails++; $display("FAIL post_rst_active_b n=%0d: got %b expected %b", n, bus.active_b, exp_ab); end
        end
    endtask

    task automatic test_sel_glitch();
        for (int k = 21; k <= 50; k++) begin
            tick();
            if (n == 29) bus.sel_clkb = 1'b0;
            if (n == 30) bus.sel_clkb = 1'b1;
            exp_clk = ((n / 7) % 2) == 1;
            exp_sw  = (n >= 32) && (n <= 34);
            exp_ab  = !exp_sw;
            checks++;
            if (bus.clk_o !== exp_clk) begin fails++; $display("FAIL glitch_clk_o n=%0d: got %b expected %b", n, bus.clk_o, exp_clk); end
            checks++;
            if (bus.switching !== exp_sw) begin fails++; $display("FAIL glitch_switching n=%0d: got %b expected %b", n, bus.switching, exp_sw); end
            checks++;
            if (bus.active_b !== exp_ab) begin fails++; $display("FAIL glitch_active_b n=%0d: got %b expected %b", n, bus.active_b, exp_ab); end
        end
    endtask

    task automatic test_pulse_widths();
        checks++;
        if (min_hi !== 2) begin fails++; $display("FAIL min_high_pulse: got %0d expected 2", min_hi); end
        checks++;
        if (min_lo !== 2) begin fails++; $display("FAIL min_low_pulse: got %0d expected 2", min_lo); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.sel_clkb = 1'b0;
        n            = 0;
        checks       = 0;
        fails        = 0;
        run_len      = 0;
        prev_clk     = 1'b0;
        run_valid    = 1'b0;
        min_hi       = 1000;
        min_lo       = 1000;
        test_reset();
        test_a_to_b();
        test_b_to_a();
        test_abort();
        test_sync_reset();
        test_sel_glitch();
        test_pulse_widths();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
